// File: rtl/text_renderer.sv
// Single-line text overlay: character line buffer, two-stage glyph-ROM render pipeline,
// clear sequencer and frame-based blink generator.
module text_renderer #(
    parameter int NUM_CHARS    = 16,
    parameter int TEXT_X       = 0,
    parameter int TEXT_Y       = 0,
    parameter int SCALE_LOG2   = 0,
    parameter int CODE_OFFSET  = 30,
    parameter int BLINK_FRAMES = 30
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [9:0]                   hcount,
    input  logic [9:0]                   vcount,
    input  logic                         video_on,
    input  logic                         wr_en,
    input  logic [$clog2(NUM_CHARS)-1:0] wr_idx,
    input  logic [7:0]                   wr_char,
    input  logic                         clr,
    input  logic                         blink_en,
    output logic                         busy,
    output logic [7:0]                   char_addr,
    output logic [2:0]                   row_addr,
    input  logic [7:0]                   bitmap,
    output logic                         pixel_on,
    output logic                         video_on_d
);

    localparam int         IDX_W      = $clog2(NUM_CHARS);
    localparam int         BOX_W      = NUM_CHARS * 8 * (2 ** SCALE_LOG2);
    localparam int         BOX_H      = 8 * (2 ** SCALE_LOG2);
    localparam int         FC_W       = $clog2(BLINK_FRAMES) + 1;
    localparam logic [7:0] SPACE      = 8'h20;
    localparam logic [7:0] SPACE_ADDR = 8'(32 - CODE_OFFSET);

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t           state, next_state;
    logic [IDX_W-1:0] clr_idx;
    logic [7:0]       buffer [NUM_CHARS];
    logic             buf_we;
    logic [IDX_W-1:0] buf_widx;
    logic [7:0]       buf_wdata;

    // Extra top bit catches coordinates left of / above the box as a wrapped negative.
    logic [10:0] rx_full, ry_full;
    logic        in_box;
    logic [IDX_W-1:0] char_idx;

    logic [2:0]  bitcol_s1;
    logic        in_box_s1, video_on_s1;
    logic [FC_W-1:0] frame_cnt;
    logic        blink_phase;

    assign rx_full  = {1'b0, hcount} - 11'(TEXT_X);
    assign ry_full  = {1'b0, vcount} - 11'(TEXT_Y);
    assign in_box   = video_on && !rx_full[10] && (rx_full < 11'(BOX_W))
                               && !ry_full[10] && (ry_full < 11'(BOX_H));
    assign char_idx = rx_full[3+SCALE_LOG2 +: IDX_W];
    assign busy     = (state == CLEAR);

    // NOTE: every signal driven here gets a default first so no path can infer a latch.
    always_comb begin
        next_state = state;
        buf_we     = 1'b0;
        buf_widx   = wr_idx;
        buf_wdata  = wr_char;
        case (state)
            IDLE: begin
                if (clr)        next_state = CLEAR;
                else if (wr_en) buf_we     = 1'b1;
            end
            CLEAR: begin
                buf_we    = 1'b1;
                buf_widx  = clr_idx;
                buf_wdata = SPACE;
                if (clr_idx == IDX_W'(NUM_CHARS - 1)) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // NOTE: state updates use non-blocking assignments so all registers sample pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            clr_idx <= '0;
        end else begin
            state   <= next_state;
            clr_idx <= (state == CLEAR) ? clr_idx + 1'b1 : '0;
        end
    end

    // NOTE: the line buffer is a small register file, so it is reset to spaces; a clear can
    // be aborted by reset and must still leave a blank line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CHARS; i++) buffer[i] <= SPACE;
        end else if (buf_we) begin
            buffer[buf_widx] <= buf_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            char_addr   <= SPACE_ADDR;
            row_addr    <= '0;
            bitcol_s1   <= '0;
            in_box_s1   <= 1'b0;
            video_on_s1 <= 1'b0;
        end else begin
            char_addr   <= in_box ? buffer[char_idx] - 8'(CODE_OFFSET) : SPACE_ADDR;
            row_addr    <= in_box ? ry_full[SCALE_LOG2 +: 3] : 3'd0;
            bitcol_s1   <= rx_full[SCALE_LOG2 +: 3];
            in_box_s1   <= in_box;
            video_on_s1 <= video_on;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pixel_on   <= 1'b0;
            video_on_d <= 1'b0;
        end else begin
            pixel_on   <= in_box_s1 & bitmap[3'd7 - bitcol_s1] & ~(blink_en & blink_phase);
            video_on_d <= video_on_s1;
        end
    end

    // Frame start is the sampled (0,0) coordinate, regardless of blink_en.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (hcount == 10'd0 && vcount == 10'd0) begin
            if (frame_cnt == FC_W'(BLINK_FRAMES - 1)) begin
                frame_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                frame_cnt <= frame_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_text_renderer.sv
// Directed bench for text_renderer: a default instance and a 2x-scaled, fast-blink instance
// share stimulus; each has its own glyph ROM model.
module tb_text_renderer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [9:0] hcount, vcount;
    logic       video_on, wr_en, clr, blink_en;
    logic [3:0] wr_idx;
    logic [7:0] wr_char;
    logic       busy_a, busy_b, pixel_a, pixel_b, vod_a, vod_b;
    logic [7:0] caddr_a, caddr_b, bitmap_a, bitmap_b;
    logic [2:0] raddr_a, raddr_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Glyph ROM model: 0x23 = 'A', 0x2A = 'H', everything else (including space 0x02) blank.
    function automatic logic [7:0] rom(input logic [7:0] ca, input logic [2:0] r);
        case (ca)
            8'h23:   return (r == 3'd0) ? 8'b0011_0000 : 8'b1111_1100;
            8'h2A:   return (r == 3'd3) ? 8'b1111_1110 : 8'b1100_0110;
            default: return 8'h00;
        endcase
    endfunction

    assign bitmap_a = rom(caddr_a, raddr_a);
    assign bitmap_b = rom(caddr_b, raddr_b);

    text_renderer u_dut_a (
        .clk(clk), .rst_n(rst_n), .hcount(hcount), .vcount(vcount), .video_on(video_on),
        .wr_en(wr_en), .wr_idx(wr_idx), .wr_char(wr_char), .clr(clr), .blink_en(blink_en),
        .busy(busy_a), .char_addr(caddr_a), .row_addr(raddr_a), .bitmap(bitmap_a),
        .pixel_on(pixel_a), .video_on_d(vod_a)
    );

    text_renderer #(.SCALE_LOG2(1), .BLINK_FRAMES(2)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .hcount(hcount), .vcount(vcount), .video_on(video_on),
        .wr_en(wr_en), .wr_idx(wr_idx), .wr_char(wr_char), .clr(clr), .blink_en(blink_en),
        .busy(busy_b), .char_addr(caddr_b), .row_addr(raddr_b), .bitmap(bitmap_b),
        .pixel_on(pixel_b), .video_on_d(vod_b)
    );

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_char(input logic [3:0] idx, input logic [7:0] ch);
        wr_en = 1'b1; wr_idx = idx; wr_char = ch;
        step();
        wr_en = 1'b0;
    endtask

    task automatic frame_start();
        hcount = 10'd0; vcount = 10'd0;
        step();
        hcount = 10'd16; vcount = 10'd6;
    endtask

    initial begin
        int busy_cycles;
        rst_n = 1'b0; hcount = 10'd0; vcount = 10'd0; video_on = 1'b1;
        wr_en = 1'b0; wr_idx = '0; wr_char = '0; clr = 1'b0; blink_en = 1'b0;
        step(); step();

        check("rst_pixel_on",   32'(pixel_a), 32'h0);
        check("rst_video_on_d", 32'(vod_a),   32'h0);
        check("rst_busy",       32'(busy_a),  32'h0);
        check("rst_char_addr",  32'(caddr_a), 32'h02);
        check("rst_row_addr",   32'(raddr_a), 32'h0);
        check("rst_char_addr_b", 32'(caddr_b), 32'h02);

        // 'A' at index 0 while rendering (0,0): same-edge read sees the old space.
        rst_n = 1'b1;
        write_char(4'd0, 8'h41);
        check("wr_same_cycle_old", 32'(caddr_a), 32'h02);
        check("vod_first_edge",    32'(vod_a),   32'h0);
        step();
        check("a_char_addr", 32'(caddr_a), 32'h23);
        check("a_row_addr",  32'(raddr_a), 32'h0);
        check("vod_second_edge", 32'(vod_a), 32'h1);
        step();
        check("a_col0_pixel", 32'(pixel_a), 32'h0);
        hcount = 10'd2;
        step(); step();
        check("a_col2_pixel", 32'(pixel_a), 32'h1);
        check("a_col2_vod",   32'(vod_a),   32'h1);

        // 2x scale: 'H' at index 1, columns 16..17, rows 6..7 map to glyph row 3, bit 0.
        hcount = 10'd16; vcount = 10'd6;
        write_char(4'd1, 8'h48);
        step();
        check("b_char_addr", 32'(caddr_b), 32'h2A);
        check("b_row_addr",  32'(raddr_b), 32'h3);
        hcount = 10'd17; vcount = 10'd7;
        step();
        check("b_row_addr_v7", 32'(raddr_b), 32'h3);
        check("b_pixel_h16",   32'(pixel_b), 32'h1);
        step();
        check("b_pixel_h17",   32'(pixel_b), 32'h1);

        // Right edge of the default box.
        hcount = 10'd127; vcount = 10'd3;
        step();
        check("edge_in_row",  32'(raddr_a), 32'h3);
        hcount = 10'd128;
        step();
        check("edge_out_char", 32'(caddr_a), 32'h02);
        check("edge_out_row",  32'(raddr_a), 32'h0);
        step();
        check("edge_out_pixel", 32'(pixel_a), 32'h0);

        // Lit pixel with video_on low.
        hcount = 10'd2; vcount = 10'd0; video_on = 1'b0;
        step(); step();
        check("video_off_pixel", 32'(pixel_a), 32'h0);
        check("video_off_vod",   32'(vod_a),   32'h0);
        video_on = 1'b1;

        // Fill, then clear with a simultaneous write that must be dropped.
        for (int i = 0; i < 16; i++) write_char(4'(i), 8'h41);
        clr = 1'b1; wr_en = 1'b1; wr_idx = 4'd5; wr_char = 8'h5A;
        step();
        clr = 1'b0; wr_idx = 4'd3; wr_char = 8'h41;
        busy_cycles = 0;
        while (busy_a && busy_cycles < 40) begin
            busy_cycles++;
            step();
        end
        wr_en = 1'b0;
        check("clear_busy_cycles", 32'(busy_cycles), 32'd16);
        for (int i = 0; i < 16; i++) begin
            hcount = 10'(i * 8); vcount = 10'd0;
            step();
            check($sformatf("clear_idx%0d", i), 32'(caddr_a), 32'h02);
        end

        // Reset in the middle of a clear.
        hcount = 10'd16; vcount = 10'd6;
        write_char(4'd7, 8'h41);
        clr = 1'b1;
        step();
        clr = 1'b0;
        check("midclr_busy_before", 32'(busy_a), 32'h1);
        step(); step();
        rst_n = 1'b0;
        #1;
        check("midclr_busy_a", 32'(busy_a), 32'h0);
        check("midclr_busy_b", 32'(busy_b), 32'h0);
        check("midclr_char",   32'(caddr_a), 32'h02);
        hcount = 10'd56; vcount = 10'd1;
        #2;
        rst_n = 1'b1;
        step();
        check("post_rst_idx7", 32'(caddr_a), 32'h02);
        check("post_rst_row",  32'(raddr_a), 32'h1);
        check("post_rst_vod0", 32'(vod_a),   32'h0);
        step();
        check("post_rst_vod1", 32'(vod_a),   32'h1);

        // Blink on the 2-frame instance.
        hcount = 10'd16; vcount = 10'd6;
        write_char(4'd1, 8'h48);
        blink_en = 1'b1;
        step(); step();
        check("blink_lit",     32'(pixel_b), 32'h1);
        frame_start();
        step(); step();
        check("blink_frame1",  32'(pixel_b), 32'h1);
        frame_start();
        step(); step();
        check("blink_blanked", 32'(pixel_b), 32'h0);
        frame_start();
        frame_start();
        step(); step();
        check("blink_restored", 32'(pixel_b), 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/text_renderer.md
TEXT_RENDERER -- requirements
Module: text_renderer

Interface
REQ-001 Parameters SHALL be, one per line:
- NUM_CHARS, 16, text-line length in characters (power of two).
- TEXT_X, 0, left pixel column of text box.
- TEXT_Y, 0, top pixel row of text box.
- SCALE_LOG2, 0, glyph magnification 2^SCALE_LOG2 (0..2).
- CODE_OFFSET, 30, value subtracted from ASCII code to form glyph ROM char_addr.
- BLINK_FRAMES, 30, frames per blink half-period.

REQ-002 Ports SHALL be, one per line:
- clk  in  1  single system/pixel clock, all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- hcount  in  10  current pixel column.
- vcount  in  10  current pixel row.
- video_on  in  1  active-video qualifier for hcount/vcount.
- wr_en  in  1  write one character into line buffer.
- wr_idx  in  $clog2(NUM_CHARS)  buffer index for write.
- wr_char  in  8  ASCII code to write.
- clr  in  1  pulse: fill buffer with spaces.
- blink_en  in  1  enable text blinking.
- busy  out  1  clear sequence in progress.
- char_addr  out  8  glyph ROM character address.
- row_addr  out  3  glyph ROM row (0 = top).
- bitmap  in  8  glyph ROM row data, combinational from char_addr/row_addr, bit 7 = leftmost pixel.
- pixel_on  out  1  text foreground at delayed pixel.
- video_on_d  out  1  video_on delayed to align with pixel_on.

Function
REQ-003 Text box SHALL span hcount in [TEXT_X, TEXT_X + NUM_CHARS*8*2^SCALE_LOG2) and vcount in [TEXT_Y, TEXT_Y + 8*2^SCALE_LOG2); in_box = both conditions and video_on.
REQ-004 With rx = hcount-TEXT_X, ry = vcount-TEXT_Y: char index = rx >> (3+SCALE_LOG2); bit column = (rx >> SCALE_LOG2) & 7; glyph row = (ry >> SCALE_LOG2) & 7.
REQ-005 Stage 1 (registered at cycle N+1 from cycle-N inputs) SHALL drive char_addr = buffer[char index] - CODE_OFFSET (mod 256), row_addr = glyph row, and register bit column and in_box.
REQ-006 Outside box, stage 1 SHALL drive char_addr = 8'h20 - CODE_OFFSET and row_addr = 0.
REQ-007 Stage 2 (cycle N+2) SHALL register pixel_on = in_box_s1 & bitmap[7 - bitcol_s1] & ~blank; total latency exactly 2 cycles; video_on_d = video_on delayed 2 cycles.
REQ-008 Buffer SHALL be NUM_CHARS x 8-bit registers; write in IDLE with wr_en=1 updates buffer[wr_idx] at next edge; same-cycle stage-1 read of that index SHALL return old value.
REQ-009 Control FSM states IDLE, CLEAR. IDLE -> CLEAR on clr=1; CLEAR writes 8'h20 to index 0,1,...,NUM_CHARS-1, one per cycle; after index NUM_CHARS-1 returns to IDLE.
REQ-010 busy SHALL be 1 exactly while in CLEAR (NUM_CHARS cycles, rising the cycle after clr sampled).
REQ-011 In CLEAR, wr_en and clr SHALL be ignored; in IDLE, clr and wr_en together: clr wins, write dropped.
REQ-012 Rendering SHALL continue during CLEAR using current buffer contents.
REQ-013 Frame counter SHALL increment when hcount==0 and vcount==0 sampled; at BLINK_FRAMES-1 it wraps to 0 and blink_phase toggles.
REQ-014 blank = blink_en & blink_phase; blink_en=0 does not stop counter.

Reset
REQ-015 On rst_n=0 (asynchronous): pixel_on=0, video_on_d=0, busy=0, FSM=IDLE, all buffer entries=8'h20, char_addr=8'h20-CODE_OFFSET (8'h02 default), row_addr=0, pipeline in_box flags=0, frame counter=0, blink_phase=0.
REQ-016 Reset asserted mid-CLEAR SHALL abort clear; buffer ends all-space from reset itself.
REQ-017 First outputs after rst_n release SHALL reflect inputs sampled at first post-release edge (2-cycle latency honoured).

Verification
REQ-018 Write 'A'(0x41) at idx 0, hcount=0,vcount=0,video_on=1 (defaults) -> cycle+1 char_addr=0x23,row_addr=0; ROM model bitmap=8'b00110000 -> cycle+2 pixel_on=0; at hcount=2 pixel_on=1.
REQ-019 SCALE_LOG2=1, 'H' at idx 1: hcount=16..17 vcount=6..7 -> row_addr=3, bitcol=0, pixel_on=1 for both columns.
REQ-020 hcount=NUM_CHARS*8 (128), vcount=0 -> char_addr=0x02, pixel_on=0 after 2 cycles; video_on=0 inside box -> pixel_on=0.
REQ-021 Fill buffer, pulse clr with simultaneous wr_en -> busy high 16 cycles, write dropped, all entries 0x20, wr_en during busy ignored.
REQ-022 blink_en=1, BLINK_FRAMES=2, lit pixel -> 2 frame starts later pixel_on forced 0, 2 more restores it; rst_n pulse mid-CLEAR -> busy=0 immediately, buffer all 0x20.
